// File: rtl/program_loader.sv
// program_loader: boot-time image loader.
// Accepts a length-prefixed, XOR-checksummed byte stream, packs it into
// 32-bit words written to RAM from BASE_ADDR upward, and releases the CPU
// from reset only after the whole image is written and the checksum matches.
module program_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_enable,
  output logic                  mem_read_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_run,
  output logic [15:0]           words_written
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state_q;
  logic [15:0]             len_q;
  logic [7:0]              xor_q;
  logic [1:0]              idx_q;
  logic [23:0]             word_q;
  logic [15:0]             words_q;
  logic                    mem_en_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             data_q;
  logic                    done_q;
  logic                    error_q;
  logic                    cpu_run_q;

  logic                    take;
  logic [7:0]              xor_d;
  logic [15:0]             len_d;
  logic [16:0]             words_inc_d;

  // Handshake and running-checksum helpers for the FSM below.
  assign take        = byte_valid && byte_ready;
  assign xor_d       = xor_q ^ byte_in;
  assign len_d       = {len_q[15:8], byte_in};
  assign words_inc_d = {1'b0, words_q} + 17'd1;

  // Status that is a pure function of the state register.
  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
  assign busy       = byte_ready || (state_q == S_WRITE);

  assign mem_enable     = mem_en_q;
  assign mem_read_write = mem_en_q;
  assign mem_address    = addr_q;
  assign mem_data_in    = data_q;
  assign done           = done_q;
  assign error          = error_q;
  assign cpu_run        = cpu_run_q;
  assign words_written  = words_q;

  // Loader FSM with all datapath and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      xor_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      words_q   <= '0;
      mem_en_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cpu_run_q <= 1'b0;
    end else begin
      // NOTE: non-blocking default drops the strobe every cycle; only the
      // transition into WRITE raises it, so it is high for exactly that cycle.
      mem_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q   <= S_LEN_HI;
            xor_q     <= '0;
            idx_q     <= '0;
            words_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_run_q <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (take) begin
            len_q[15:8] <= byte_in;
            xor_q       <= xor_d;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (take) begin
            len_q[7:0] <= byte_in;
            xor_q      <= xor_d;
            state_q    <= (len_d != 16'd0) ? S_DATA : S_CSUM;
          end
        end
        S_DATA: begin
          if (take) begin
            xor_q <= xor_d;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              // Last byte of the word goes straight to the write register.
              data_q   <= {word_q, byte_in};
              addr_q   <= BaseAddr + ADDR_WIDTH'(words_q);
              mem_en_q <= 1'b1;
              state_q  <= S_WRITE;
            end else begin
              word_q <= {word_q[15:0], byte_in};
            end
          end
        end
        S_WRITE: begin
          words_q <= words_inc_d[15:0];
          state_q <= (words_inc_d < {1'b0, len_q}) ? S_DATA : S_CSUM;
        end
        S_CSUM: begin
          if (take) begin
            if (byte_in == xor_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              cpu_run_q <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: two instances (base 0 and base 0xFFFF) share
// one byte stream; a model builds each image and predicts writes and status.
module tb_program_loader;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, byte_valid;
  logic [7:0]  byte_in;

  logic        byte_ready0, mem_enable0, mem_read_write0, busy0, done0, error0, cpu_run0;
  logic [15:0] mem_address0, words_written0;
  logic [31:0] mem_data_in0;
  logic        byte_ready1, mem_enable1, mem_read_write1, busy1, done1, error1, cpu_run1;
  logic [15:0] mem_address1, words_written1;
  logic [31:0] mem_data_in1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;

  wr_t  wq0[$];
  wr_t  wq1[$];
  logic en0_prev = 1'b0;
  logic en1_prev = 1'b0;

  program_loader #(.ADDR_WIDTH(16), .BASE_ADDR(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready0), .mem_enable(mem_enable0),
    .mem_read_write(mem_read_write0), .mem_address(mem_address0),
    .mem_data_in(mem_data_in0), .busy(busy0), .done(done0), .error(error0),
    .cpu_run(cpu_run0), .words_written(words_written0)
  );

  program_loader #(.ADDR_WIDTH(16), .BASE_ADDR('hFFFF)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready1), .mem_enable(mem_enable1),
    .mem_read_write(mem_read_write1), .mem_address(mem_address1),
    .mem_data_in(mem_data_in1), .busy(busy1), .done(done1), .error(error1),
    .cpu_run(cpu_run1), .words_written(words_written1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every strobe, checks it is one cycle wide and a write.
  always @(negedge clk) begin
    wr_t e;
    if (mem_enable0) begin
      chk("en_width0", {31'd0, en0_prev}, 32'd0);
      e.addr = mem_address0;
      e.data = mem_data_in0;
      wq0.push_back(e);
    end
    if (mem_enable1) begin
      chk("en_width1", {31'd0, en1_prev}, 32'd0);
      e.addr = mem_address1;
      e.data = mem_data_in1;
      wq1.push_back(e);
    end
    chk("rw0", {31'd0, mem_read_write0}, {31'd0, mem_enable0});
    chk("rw1", {31'd0, mem_read_write1}, {31'd0, mem_enable1});
    en0_prev = mem_enable0;
    en1_prev = mem_enable1;
  end

  task automatic check_reset_vals(input string where);
    chk({where, " flags0"}, {25'd0, byte_ready0, mem_enable0, mem_read_write0, busy0,
                             done0, error0, cpu_run0}, 32'd0);
    chk({where, " addr0"}, {16'd0, mem_address0}, 32'd0);
    chk({where, " data0"}, mem_data_in0, 32'd0);
    chk({where, " ww0"}, {16'd0, words_written0}, 32'd0);
    chk({where, " flags1"}, {25'd0, byte_ready1, mem_enable1, mem_read_write1, busy1,
                             done1, error1, cpu_run1}, 32'd0);
    chk({where, " addr1"}, {16'd0, mem_address1}, 32'd0);
    chk({where, " data1"}, mem_data_in1, 32'd0);
    chk({where, " ww1"}, {16'd0, words_written1}, 32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    chk("start busy", {30'd0, busy0, busy1}, 32'd3);
    chk("start ready", {30'd0, byte_ready0, byte_ready1}, 32'd3);
  endtask

  // Present one byte and hold it until an edge where the loader was ready.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit   ok;
    logic rdy;
    if (stall) begin
      for (int n = 0; n < 3 && $urandom_range(0, 1) == 1; n++) begin
        byte_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
    end
    byte_in = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rdy = byte_ready0;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("byte_timeout", {31'd0, ok}, 32'd1);
  endtask

  function automatic wq_t build_stream(input wq_t w, input bit corrupt);
    wq_t         s;
    logic [15:0] n16;
    logic [7:0]  x;
    n16 = 16'(w.size());
    s.push_back({24'd0, n16[15:8]});
    s.push_back({24'd0, n16[7:0]});
    foreach (w[k]) begin
      s.push_back({24'd0, w[k][31:24]});
      s.push_back({24'd0, w[k][23:16]});
      s.push_back({24'd0, w[k][15:8]});
      s.push_back({24'd0, w[k][7:0]});
    end
    x = 8'd0;
    foreach (s[i]) x = x ^ s[i][7:0];
    s.push_back({24'd0, corrupt ? (x ^ 8'h01) : x});
    return s;
  endfunction

  task automatic run_load(input wq_t w, input bit corrupt, input bit stall,
                          input bit do_st, input bit hold_start, input string tag);
    wq_t         s;
    int          n;
    logic [15:0] a1;
    n = w.size();
    s = build_stream(w, corrupt);
    wq0.delete();
    wq1.delete();
    if (do_st) do_start();
    if (hold_start) start = 1'b1;
    foreach (s[i]) begin
      if (i == s.size() - 1) start = 1'b0;
      send_byte(s[i][7:0], stall);
    end
    byte_valid = 1'b0;
    chk({tag, " done"}, {29'd0, done0, error0, cpu_run0}, corrupt ? 32'd2 : 32'd5);
    chk({tag, " done1"}, {29'd0, done1, error1, cpu_run1}, corrupt ? 32'd2 : 32'd5);
    chk({tag, " idle"}, {28'd0, busy0, byte_ready0, busy1, byte_ready1}, 32'd0);
    chk({tag, " ww0"}, {16'd0, words_written0}, n);
    chk({tag, " ww1"}, {16'd0, words_written1}, n);
    if (!stall) chk({tag, " cycles"}, cyc - start_cyc, 3 + 5 * n);
    chk({tag, " nwr0"}, wq0.size(), n);
    chk({tag, " nwr1"}, wq1.size(), n);
    for (int k = 0; k < n && k < wq0.size() && k < wq1.size(); k++) begin
      a1 = 16'hFFFF + 16'(k);
      chk($sformatf("%s addr0[%0d]", tag, k), {16'd0, wq0[k].addr}, k);
      chk($sformatf("%s data0[%0d]", tag, k), wq0[k].data, w[k]);
      chk($sformatf("%s addr1[%0d]", tag, k), {16'd0, wq1[k].addr}, {16'd0, a1});
      chk($sformatf("%s data1[%0d]", tag, k), wq1[k].data, w[k]);
    end
    if (n > 0) begin
      chk({tag, " hold addr"}, {16'd0, mem_address0}, n - 1);
      chk({tag, " hold data"}, mem_data_in0, w[n-1]);
    end
  endtask

  initial begin
    wq_t nom, empty, rnd, s;
    nom = '{32'hDEADBEEF, 32'h12345678};
    empty = {};

    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    run_load(nom, 1'b0, 1'b0, 1'b1, 1'b0, "nominal");
    run_load(nom, 1'b1, 1'b0, 1'b1, 1'b0, "badcsum");
    run_load(nom, 1'b0, 1'b0, 1'b1, 1'b0, "recover");
    run_load(empty, 1'b0, 1'b0, 1'b1, 1'b0, "zero");
    run_load(nom, 1'b0, 1'b1, 1'b1, 1'b0, "stall");

    // Reset during the first WRITE cycle.
    s = build_stream(nom, 1'b0);
    wq0.delete();
    wq1.delete();
    do_start();
    for (int i = 0; i < 6; i++) send_byte(s[i][7:0], 1'b0);
    byte_valid = 1'b0;
    chk("mid en", {31'd0, mem_enable0}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("midreset");
    chk("mid nwr", wq0.size(), 32'd1);
    if (wq0.size() > 0) chk("mid data", wq0[0].data, 32'hDEADBEEF);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("postreset");
    run_load(nom, 1'b0, 1'b0, 1'b1, 1'b0, "reload");

    // start held high for the whole load must not restart it.
    run_load(nom, 1'b0, 1'b0, 1'b1, 1'b1, "busystart");

    // start from DONE together with a valid byte: byte must not be consumed.
    s = build_stream(nom, 1'b0);
    start = 1'b1;
    byte_valid = 1'b1;
    byte_in = s[0][7:0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    chk("restart run", {28'd0, cpu_run0, done0, cpu_run1, done1}, 32'd0);
    chk("restart busy", {31'd0, busy0}, 32'd1);
    run_load(nom, 1'b0, 1'b0, 1'b0, 1'b0, "restart");

    for (int r = 0; r < 6; r++) begin
      int nw;
      bit bad;
      rnd = {};
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) rnd.push_back($urandom);
      bad = ($urandom_range(0, 3) == 0);
      run_load(rnd, bad, 1'b1, 1'b1, 1'b0, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits directly upstream of the CPU's unified RAM and state machine. It receives a program image as a byte stream with a valid/ready handshake and packs it into 32-bit words. Each word is written into RAM at consecutive addresses from `BASE_ADDR`. The block holds the CPU in reset until the image is fully written and its checksum verifies, replacing the file-based RAM preload for hardware bring-up.

## Interface
- `ADDR_WIDTH`, default 16: RAM word-address width; matches the CPU address bus.
- `BASE_ADDR`, default 0: address of the first loaded word.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a load; sampled only in IDLE, DONE and ERROR.
- `byte_in`  in  8: stream byte.
- `byte_valid`  in  1: `byte_in` is valid.
- `byte_ready`  out  1: loader can accept a byte this cycle.
- `mem_enable`  out  1: RAM enable strobe.
- `mem_read_write`  out  1: 1 = write, 0 = read; the loader only ever writes.
- `mem_address`  out  ADDR_WIDTH: RAM word address.
- `mem_data_in`  out  32: RAM write data.
- `busy`  out  1: a load is in progress.
- `done`  out  1: image loaded and checksum matched.
- `error`  out  1: checksum mismatch.
- `cpu_run`  out  1: 1 releases the CPU; 0 holds the CPU in reset.
- `words_written`  out  16: count of RAM writes issued in the current or last load.

## Operation
- Stream format, in order:
  - LEN_HI byte, then LEN_LO byte, forming word count N (16-bit, big-endian).
  - N×4 data bytes; each word is sent MSB first.
  - One checksum byte equal to the XOR of every preceding byte, including both length bytes.
- A byte is consumed on a rising edge where `byte_valid && byte_ready`.
- `byte_ready` = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in every other state.
- States and transitions:
  - IDLE: on `start`, go to LEN_HI. Clear the running XOR, byte index, `words_written`, `done` and `error`.
  - LEN_HI: on a consumed byte, go to LEN_LO.
  - LEN_LO: on a consumed byte, go to DATA if N≠0, otherwise to CSUM.
  - DATA: shift the consumed byte into the word register. On the 4th byte, go to WRITE.
  - WRITE: one cycle. Go to DATA if `words_written`+1 < N, otherwise to CSUM. Increment `words_written`.
  - CSUM: on a consumed byte, go to DONE if it equals the running XOR, otherwise to ERROR.
  - DONE: `done`=1, `cpu_run`=1. On `start`, go to LEN_HI with the same clearing as IDLE; `cpu_run` drops.
  - ERROR: `error`=1, `cpu_run`=0. On `start`, go to LEN_HI with the same clearing as IDLE.
- `busy` = 1 in LEN_HI, LEN_LO, DATA, WRITE and CSUM.
- `start` is ignored while `busy`=1.
- Write k (k from 0) targets `BASE_ADDR`+k modulo 2^ADDR_WIDTH; the address wraps silently.
- Words already written are not rolled back on ERROR or reset.

## Timing
- Reset values: state IDLE.
  - All outputs 0: `byte_ready`, `mem_enable`, `mem_read_write`, `mem_address`, `mem_data_in`, `busy`, `done`, `error`, `cpu_run`, `words_written`.
- Reset asserted mid-load forces IDLE and all the values above immediately (asynchronously).
  - Any `mem_enable` pulse in flight is cut short.
- `mem_enable` and `mem_read_write` are 1 only during the WRITE cycle.
  - `mem_address` and `mem_data_in` are stable for that whole cycle and are registered outputs.
  - They hold their last values otherwise.
- Latency: 4th data byte consumed at edge t → WRITE during cycle t..t+1 → `byte_ready` back to 1 from edge t+1.
  - A byte presented during WRITE is not consumed; the source must hold it.
- `start` seen at edge t → `byte_ready`=1 and `busy`=1 from edge t.
- Checksum byte consumed at edge t → `done`/`cpu_run` (or `error`) = 1 from edge t.
- `start` in DONE at edge t → `cpu_run`=0 and `done`=0 from edge t.
- Throughput: a full-rate source gives 5 cycles per word (4 byte cycles plus 1 WRITE cycle).
- `start` and a byte in the same cycle: `start` takes effect; the byte is not consumed, because `byte_ready` was 0.

## Test plan
- Nominal load: `start`, then bytes 00 02 DE AD BE EF 12 34 56 78 28 at full rate.
  - → write 0xDEADBEEF to address 0, then 0x12345678 to address 1.
  - → each `mem_enable` pulse is 1 cycle; `words_written`=2; `done`=`cpu_run`=1; `error`=0.
- Bad checksum: same stream with last byte 29.
  - → both writes still occur; `error`=1, `cpu_run`=0.
  - → a later `start` plus a correct stream ends in `done`=1.
- Zero length: bytes 00 00 00.
  - → no `mem_enable` pulse; `words_written`=0; `done`=1.
- Stalls: nominal stream with `byte_valid` toggled randomly and a byte held through each WRITE cycle.
  - → identical writes to the nominal load; no byte is dropped or duplicated.
- Reset mid-load: assert `reset` after the first WRITE.
  - → all outputs 0 in the same cycle and state IDLE.
  - → reload of the nominal stream completes with `done`=1.
- Restart and wrap: with `BASE_ADDR`=0xFFFF, load 2 words → writes go to 0xFFFF then 0x0000.
  - `start` while `busy` → ignored.
  - `start` after DONE → `cpu_run` falls on the next edge.
